i2c_line_driver: RTL and testbench
==================================

Name: i2c_line_driver

Overview:
Output-side companion to the input glitch filter in the I2C slave path. It drives the open-drain SDA and SCL pull-down enables from the slave state machine's requests. SDA changes only while SCL is low, and only after a programmable data-hold time following SCL fall. SCL is stretched (held low) on request, bounded by a timeout. On each SCL rise it compares the intended SDA level with the filtered bus level and flags any mismatch.

Parameters:
HOLD_CYCLES, 4, clk cycles from observed SCL fall to first permitted SDA change (tHD;DAT); legal range 1..255
STRETCH_MAX, 65535, max clk cycles SCL may be stretched; 0 disables the timeout
CNT_W, 16, width of the stretch counter; must hold STRETCH_MAX

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  asynchronous, active-low reset
scl_in  in  1  filtered SCL level (glitch filter out)
scl_rise  in  1  filtered SCL rising-edge qualifier
scl_fall  in  1  filtered SCL falling-edge qualifier
sda_in  in  1  filtered SDA level
sda_req  in  1  desired SDA level from slave FSM (1 = release, 0 = pull low)
stretch_req  in  1  slave FSM requests SCL be held low
sda_oe  out  1  1 = drive SDA low, 0 = release
scl_oe  out  1  1 = drive SCL low, 0 = release
hold_done  out  1  high while SCL is low and the hold window has elapsed
mismatch  out  1  one-cycle pulse: SDA released but bus low at SCL rise
stretch_timeout  out  1  one-cycle pulse when a stretch is force-released

Behaviour:
- Reset (rst=0, async): sda_oe=0, scl_oe=0, hold_done=0, mismatch=0, stretch_timeout=0, hold counter=0, stretch counter=0, state=SCL_HI.
- SDA state machine, three states:
  - SCL_HI: SCL high; sda_oe frozen.
  - HOLD: SCL low; counting hold cycles; sda_oe frozen.
  - LOW_OK: SCL low; hold window over; SDA may change.
- SDA transitions:
  - SCL_HI -> HOLD on scl_fall; counter loaded with HOLD_CYCLES-1.
  - HOLD decrements each cycle; counter==0 -> LOW_OK.
  - HOLD or LOW_OK -> SCL_HI on scl_rise; scl_rise takes priority over the counter reaching zero.
  - HOLD -> SCL_HI on scl_rise without ever reaching LOW_OK: hold window aborted, sda_oe unchanged.
- sda_oe updates:
  - In LOW_OK, registered each cycle as sda_oe <= ~sda_req.
  - First update occurs on the clock edge that enters LOW_OK, i.e. exactly HOLD_CYCLES cycles after the scl_fall cycle.
  - A sda_req change during SCL_HI or HOLD is deferred until LOW_OK; only the latest value is applied.
- hold_done = (state==LOW_OK), registered.
- Mismatch check:
  - On the scl_rise cycle, mismatch <= (sda_oe==0) & (sda_in==0).
  - Never asserted while sda_oe=1.
- SCL stretch:
  - scl_oe <= 1 when stretch_req=1 and state!=SCL_HI.
  - Never asserted while SCL is observed high, so a high SCL is never pulled low.
  - scl_oe <= 0 on the cycle after stretch_req falls.
- Stretch timeout:
  - Counter increments while scl_oe=1 and clears when scl_oe=0.
  - At count==STRETCH_MAX-1 (STRETCH_MAX!=0): scl_oe <= 0 and stretch_timeout pulses one cycle.
  - After a timeout, scl_oe stays 0 until stretch_req deasserts and the next scl_fall occurs.
- scl_in=1 while in HOLD/LOW_OK with no scl_rise (e.g. filter resync): treated as scl_rise on the next cycle.
- Simultaneous scl_rise and scl_fall: impossible from the filter; scl_rise wins.
- Reset mid-transfer releases both lines immediately (asynchronous).

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings SCL_HI=2'd0, HOLD=2'd1, LOW_OK=2'd2;
  - defaults DEF_HOLD_CYCLES=4, DEF_STRETCH_MAX=65535.
- One natural sub-module: i2c_stretch_timer, containing the stretch counter, the timeout pulse and the post-timeout lockout. The SDA FSM stays in the top level.

Test Plan:
- Hold timing: HOLD_CYCLES=4; sda_req=0 while SCL high; scl_fall at cycle 10 -> sda_oe rises at cycle 14, hold_done=1 from 14; no change before 14.
- Aborted hold: scl_fall at cycle 10, scl_rise at 12, sda_req=0 throughout -> sda_oe stays 0, state back to SCL_HI, hold_done never set.
- Mismatch: sda_oe=0, sda_in=0 on the scl_rise cycle -> mismatch pulse for exactly 1 cycle; repeat with sda_in=1 -> no pulse; repeat with sda_oe=1, sda_in=0 -> no pulse.
- Stretch: stretch_req=1 while SCL high -> scl_oe stays 0; after scl_fall -> scl_oe=1 next cycle; stretch_req=0 -> scl_oe=0 one cycle later.
- Timeout: STRETCH_MAX=8, stretch_req held 1 after scl_fall -> scl_oe high 8 cycles, then 0 with a one-cycle stretch_timeout; scl_oe stays 0 until req drop plus a new scl_fall.
- Async reset: assert rst=0 mid-stretch with sda_oe=1 -> scl_oe=0 and sda_oe=0 without a clock edge; state SCL_HI after release.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C slave output path.
package i2c_pkg;

    typedef enum logic [1:0] {
        SCL_HI = 2'd0,
        HOLD   = 2'd1,
        LOW_OK = 2'd2
    } scl_state_t;

    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_STRETCH_MAX = 65535;
    localparam int HOLD_CNT_W      = 8;

endpackage

// File: rtl/i2c_stretch_timer.sv
// SCL clock-stretch enable with a bounded stretch time and a lockout that
// keeps SCL released after a forced release until the next clean low phase.
module i2c_stretch_timer
    import i2c_pkg::*;
#(
    parameter int STRETCH_MAX = DEF_STRETCH_MAX,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_stretch_req,
    input  logic i_scl_low_next,
    input  logic i_scl_fall,
    output logic o_scl_oe,
    output logic o_stretch_timeout
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(STRETCH_MAX - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_scl_oe;
    logic             r_timeout;
    logic             r_locked;
    logic             r_req_dropped;
    logic             w_timeout;
    logic             w_unlock;

    assign w_timeout = (STRETCH_MAX != 0) && r_scl_oe && (r_cnt == LP_LAST);
    // Lockout ends only on a fresh SCL fall once the request has gone away.
    assign w_unlock  = i_scl_fall && (r_req_dropped || !i_stretch_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_scl_oe      <= 1'b0;
            r_timeout     <= 1'b0;
            r_locked      <= 1'b0;
            r_req_dropped <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            r_scl_oe  <= i_stretch_req && i_scl_low_next && !w_timeout
                         && (!r_locked || w_unlock);
            r_cnt     <= (r_scl_oe && !w_timeout) ? r_cnt + CNT_W'(1) : '0;
            if (w_timeout) begin
                r_locked      <= 1'b1;
                r_req_dropped <= 1'b0;
            end else if (r_locked) begin
                if (w_unlock) begin
                    r_locked      <= 1'b0;
                    r_req_dropped <= 1'b0;
                end else if (!i_stretch_req) begin
                    r_req_dropped <= 1'b1;
                end
            end
        end
    end

    assign o_scl_oe          = r_scl_oe;
    assign o_stretch_timeout = r_timeout;

endmodule

// File: rtl/i2c_line_driver.sv
// Open-drain SDA/SCL pull-down control for the I2C slave: data-hold timed
// SDA updates, bounded clock stretching and SDA readback checking.
module i2c_line_driver
    import i2c_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int STRETCH_MAX = DEF_STRETCH_MAX,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic scl_rise,
    input  logic scl_fall,
    input  logic sda_in,
    input  logic sda_req,
    input  logic stretch_req,
    output logic sda_oe,
    output logic scl_oe,
    output logic hold_done,
    output logic mismatch,
    output logic stretch_timeout
);

    localparam logic [HOLD_CNT_W-1:0] LP_HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);

    scl_state_t            r_state;
    scl_state_t            w_state_next;
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic [HOLD_CNT_W-1:0] w_hold_cnt_next;
    logic                  r_sda_oe;
    logic                  r_hold_done;
    logic                  r_mismatch;
    logic                  w_rise;

    // A high SCL seen during a low phase without a rise qualifier (filter
    // resync) ends the low phase just like a real rise.
    assign w_rise = scl_rise | ((r_state != SCL_HI) & scl_in);

    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        case (r_state)
            SCL_HI: begin
                if (scl_fall && !scl_rise) begin
                    w_state_next    = HOLD;
                    w_hold_cnt_next = LP_HOLD_LOAD;
                end
            end
            HOLD: begin
                if (w_rise) begin
                    w_state_next = SCL_HI;
                end else if (r_hold_cnt == '0) begin
                    w_state_next = LOW_OK;
                end else begin
                    w_hold_cnt_next = r_hold_cnt - HOLD_CNT_W'(1);
                end
            end
            LOW_OK: begin
                if (w_rise) begin
                    w_state_next = SCL_HI;
                end
            end
            default: begin
                w_state_next = SCL_HI;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SCL_HI;
            r_hold_cnt  <= '0;
            r_sda_oe    <= 1'b0;
            r_hold_done <= 1'b0;
            r_mismatch  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_hold_done <= (w_state_next == LOW_OK);
            r_mismatch  <= w_rise & ~r_sda_oe & ~sda_in;
            if (w_state_next == LOW_OK) begin
                r_sda_oe <= ~sda_req;
            end
        end
    end

    // Stretch is granted from the next state so SCL is never pulled low on
    // the edge where the bus is seen rising.
    i2c_stretch_timer #(
        .STRETCH_MAX (STRETCH_MAX),
        .CNT_W       (CNT_W)
    ) u_stretch_timer (
        .clk               (clk),
        .rst               (rst),
        .i_stretch_req     (stretch_req),
        .i_scl_low_next    (w_state_next != SCL_HI),
        .i_scl_fall        (scl_fall),
        .o_scl_oe          (scl_oe),
        .o_stretch_timeout (stretch_timeout)
    );

    assign sda_oe    = r_sda_oe;
    assign hold_done = r_hold_done;
    assign mismatch  = r_mismatch;

endmodule

// File: tb/tb_i2c_line_driver.sv
// Directed scenarios plus a randomized bus run checked against a
// cycle-counting behavioural model of the line driver.
module tb_i2c_line_driver;

    localparam int HOLD = 4;
    localparam int SMAX = 8;

    logic clk = 1'b0;
    logic rst, scl_in, scl_rise, scl_fall, sda_in, sda_req, stretch_req;
    logic sda_oe, scl_oe, hold_done, mismatch, stretch_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: "low phase" flag, edges since the fall,
    // cycles the stretch has lasted, and the lockout bookkeeping.
    bit m_low, m_sda_oe, m_hold_done, m_mis, m_scl_oe, m_to, m_locked, m_dropped;
    int m_since, m_oe_cyc;

    always #5 clk = ~clk;

    i2c_line_driver #(
        .HOLD_CYCLES (HOLD),
        .STRETCH_MAX (SMAX),
        .CNT_W       (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .scl_in          (scl_in),
        .scl_rise        (scl_rise),
        .scl_fall        (scl_fall),
        .sda_in          (sda_in),
        .sda_req         (sda_req),
        .stretch_req     (stretch_req),
        .sda_oe          (sda_oe),
        .scl_oe          (scl_oe),
        .hold_done       (hold_done),
        .mismatch        (mismatch),
        .stretch_timeout (stretch_timeout)
    );

    task automatic model_reset();
        m_low = 0; m_sda_oe = 0; m_hold_done = 0; m_mis = 0; m_scl_oe = 0;
        m_to = 0; m_locked = 0; m_dropped = 0; m_since = 0; m_oe_cyc = 0;
    endtask

    task automatic model_step();
        bit rise, low_n, hold_ok, to_n, lock_eff;
        rise  = scl_rise || (m_low && scl_in);
        m_mis = rise && !m_sda_oe && !sda_in;
        if (rise) begin
            low_n = 0;
        end else if (!m_low && scl_fall) begin
            low_n = 1;
            m_since = 0;
        end else begin
            low_n = m_low;
            if (m_low) m_since++;
        end
        hold_ok = low_n && (m_since >= HOLD);
        if (hold_ok) m_sda_oe = !sda_req;
        m_hold_done = hold_ok;
        if (m_scl_oe) m_oe_cyc++; else m_oe_cyc = 0;
        to_n = m_scl_oe && (m_oe_cyc == SMAX);
        lock_eff = m_locked && !(scl_fall && (m_dropped || !stretch_req));
        if (to_n) begin
            m_locked = 1; m_dropped = 0;
        end else if (m_locked) begin
            if (!lock_eff) begin
                m_locked = 0; m_dropped = 0;
            end else if (!stretch_req) begin
                m_dropped = 1;
            end
        end
        m_scl_oe = stretch_req && low_n && !lock_eff && !to_n;
        m_to = to_n;
        m_low = low_n;
    endtask

    task automatic tick();
        if (!rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        scl_in = 1; scl_rise = 0; scl_fall = 0; sda_in = 1; sda_req = 1; stretch_req = 0;
    endtask

    task automatic do_fall();
        scl_fall = 1; scl_in = 0; tick(); scl_fall = 0;
    endtask

    task automatic do_rise();
        scl_rise = 1; scl_in = 1; tick(); scl_rise = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        repeat (3) tick();
        n_cmp++;
        if ({sda_oe, scl_oe, hold_done, mismatch, stretch_timeout} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_in: outputs=%b required=00000",
                     {sda_oe, scl_oe, hold_done, mismatch, stretch_timeout});
        end
        rst = 1;
        repeat (2) tick();
        n_cmp++;
        if ({sda_oe, scl_oe, hold_done, mismatch, stretch_timeout} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_out: outputs=%b required=00000",
                     {sda_oe, scl_oe, hold_done, mismatch, stretch_timeout});
        end
        $display("test_reset done");
    endtask

    task automatic test_hold_timing();
        bit e;
        sda_req = 0;
        repeat (2) tick();
        n_cmp++;
        if (sda_oe !== 1'b0) begin
            n_bad++; $display("FAIL hold_pre: sda_oe=%b required=0", sda_oe);
        end
        do_fall();
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            e = (k >= HOLD);
            n_cmp++;
            if ({sda_oe, hold_done} !== {e, e}) begin
                n_bad++;
                $display("FAIL hold_k%0d: sda_oe,hold_done=%b%b required=%b%b", k, sda_oe, hold_done, e, e);
            end
        end
        do_rise();
        n_cmp++;
        if ({sda_oe, hold_done, mismatch} !== 3'b100) begin
            n_bad++;
            $display("FAIL hold_rise: sda_oe,hold_done,mismatch=%b required=100", {sda_oe, hold_done, mismatch});
        end
        sda_req = 1;
        do_fall(); repeat (5) tick(); do_rise();
        n_cmp++;
        if (sda_oe !== 1'b0) begin
            n_bad++; $display("FAIL hold_release: sda_oe=%b required=0", sda_oe);
        end
        $display("test_hold_timing done");
    endtask

    task automatic test_aborted_hold();
        sda_req = 0;
        do_fall();
        tick();
        do_rise();
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if ({sda_oe, hold_done} !== 2'b00) begin
                n_bad++;
                $display("FAIL abort_k%0d: sda_oe,hold_done=%b%b required=00", k, sda_oe, hold_done);
            end
            tick();
        end
        sda_req = 1;
        $display("test_aborted_hold done");
    endtask

    task automatic test_mismatch();
        do_fall(); repeat (5) tick();
        sda_in = 0; do_rise();
        n_cmp++;
        if (mismatch !== 1'b1) begin
            n_bad++; $display("FAIL mis_pulse: mismatch=%b required=1", mismatch);
        end
        sda_in = 1; tick();
        n_cmp++;
        if (mismatch !== 1'b0) begin
            n_bad++; $display("FAIL mis_width: mismatch=%b required=0", mismatch);
        end
        do_fall(); repeat (5) tick();
        do_rise();
        n_cmp++;
        if (mismatch !== 1'b0) begin
            n_bad++; $display("FAIL mis_bus_high: mismatch=%b required=0", mismatch);
        end
        sda_req = 0;
        do_fall(); repeat (5) tick();
        sda_in = 0; do_rise();
        n_cmp++;
        if ({mismatch, sda_oe} !== 2'b01) begin
            n_bad++; $display("FAIL mis_driving: mismatch,sda_oe=%b%b required=01", mismatch, sda_oe);
        end
        sda_in = 1; sda_req = 1;
        do_fall(); repeat (5) tick(); do_rise();
        $display("test_mismatch done");
    endtask

    task automatic test_stretch();
        stretch_req = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (scl_oe !== 1'b0) begin
                n_bad++; $display("FAIL stretch_high_k%0d: scl_oe=%b required=0", k, scl_oe);
            end
        end
        do_fall();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            n_cmp++;
            if (scl_oe !== 1'b1) begin
                n_bad++; $display("FAIL stretch_low_k%0d: scl_oe=%b required=1", k, scl_oe);
            end
        end
        stretch_req = 0; tick();
        n_cmp++;
        if (scl_oe !== 1'b0) begin
            n_bad++; $display("FAIL stretch_release: scl_oe=%b required=0", scl_oe);
        end
        tick(); do_rise();
        $display("test_stretch done");
    endtask

    task automatic test_timeout();
        stretch_req = 1;
        do_fall();
        for (int k = 0; k < SMAX; k++) begin
            if (k > 0) tick();
            n_cmp++;
            if ({scl_oe, stretch_timeout} !== 2'b10) begin
                n_bad++;
                $display("FAIL to_hold_k%0d: scl_oe,timeout=%b%b required=10", k, scl_oe, stretch_timeout);
            end
        end
        tick();
        n_cmp++;
        if ({scl_oe, stretch_timeout} !== 2'b01) begin
            n_bad++; $display("FAIL to_fire: scl_oe,timeout=%b%b required=01", scl_oe, stretch_timeout);
        end
        tick();
        n_cmp++;
        if ({scl_oe, stretch_timeout} !== 2'b00) begin
            n_bad++; $display("FAIL to_after: scl_oe,timeout=%b%b required=00", scl_oe, stretch_timeout);
        end
        do_rise(); tick();
        do_fall(); tick();
        n_cmp++;
        if (scl_oe !== 1'b0) begin
            n_bad++; $display("FAIL to_lockout: scl_oe=%b required=0", scl_oe);
        end
        do_rise();
        stretch_req = 0; tick();
        stretch_req = 1; tick();
        do_fall();
        n_cmp++;
        if (scl_oe !== 1'b1) begin
            n_bad++; $display("FAIL to_unlock: scl_oe=%b required=1", scl_oe);
        end
        stretch_req = 0; tick(); do_rise();
        $display("test_timeout done");
    endtask

    task automatic test_resync();
        do_fall(); repeat (5) tick();
        n_cmp++;
        if (hold_done !== 1'b1) begin
            n_bad++; $display("FAIL resync_pre: hold_done=%b required=1", hold_done);
        end
        scl_in = 1; tick();
        n_cmp++;
        if (hold_done !== 1'b0) begin
            n_bad++; $display("FAIL resync_exit: hold_done=%b required=0", hold_done);
        end
        tick();
        do_fall(); repeat (3) tick();
        n_cmp++;
        if (hold_done !== 1'b0) begin
            n_bad++; $display("FAIL resync_early: hold_done=%b required=0", hold_done);
        end
        tick();
        n_cmp++;
        if (hold_done !== 1'b1) begin
            n_bad++; $display("FAIL resync_hold: hold_done=%b required=1", hold_done);
        end
        do_rise();
        $display("test_resync done");
    endtask

    task automatic test_async_reset();
        sda_req = 0; stretch_req = 1;
        do_fall(); repeat (5) tick();
        n_cmp++;
        if ({sda_oe, scl_oe} !== 2'b11) begin
            n_bad++; $display("FAIL areset_pre: sda_oe,scl_oe=%b%b required=11", sda_oe, scl_oe);
        end
        #2 rst = 0;
        #1;
        n_cmp++;
        if ({sda_oe, scl_oe, hold_done} !== 3'b000) begin
            n_bad++;
            $display("FAIL areset_now: sda_oe,scl_oe,hold_done=%b required=000", {sda_oe, scl_oe, hold_done});
        end
        idle_inputs();
        tick();
        rst = 1; stretch_req = 1;
        tick();
        n_cmp++;
        if ({scl_oe, hold_done} !== 2'b00) begin
            n_bad++; $display("FAIL areset_state: scl_oe,hold_done=%b%b required=00", scl_oe, hold_done);
        end
        stretch_req = 0; tick();
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        bit bus_scl = 1;
        int timer = 3;
        int nbits = 0;
        for (int c = 0; c < 1500; c++) begin
            scl_rise = 0; scl_fall = 0;
            if (bus_scl) begin
                if (timer == 0) begin
                    scl_fall = 1; bus_scl = 0; timer = $urandom_range(2, 12);
                end else timer--;
            end else if (timer == 0 && !m_scl_oe) begin
                scl_rise = 1; bus_scl = 1; timer = $urandom_range(2, 8);
            end else if (timer > 0) timer--;
            scl_in = bus_scl;
            if ($urandom_range(0, 3) == 0) sda_req = ~sda_req;
            if ($urandom_range(0, 7) == 0) stretch_req = ~stretch_req;
            sda_in = !m_sda_oe && ($urandom_range(0, 5) != 0);
            tick();
            n_cmp++;
            if ({sda_oe, scl_oe, hold_done, mismatch, stretch_timeout} !==
                {m_sda_oe, m_scl_oe, m_hold_done, m_mis, m_to}) begin
                n_bad++;
                $display("FAIL rand_c%0d: sda_oe,scl_oe,hold_done,mismatch,timeout=%b required=%b", c,
                         {sda_oe, scl_oe, hold_done, mismatch, stretch_timeout},
                         {m_sda_oe, m_scl_oe, m_hold_done, m_mis, m_to});
            end
            if (scl_rise) begin
                nbits++;
                $display("rand bit %0d: cycle=%0d sda_in=%b mismatch=%b", nbits, c, sda_in, mismatch);
            end
        end
        scl_rise = 0; scl_fall = 0; stretch_req = 0; sda_req = 1; sda_in = 1;
        if (!bus_scl) begin
            repeat (2) tick();
            do_rise();
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold_timing();
        test_aborted_hold();
        test_mismatch();
        test_stretch();
        test_timeout();
        test_resync();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
